byte_fifo: RTL and testbench

- Synchronous first-word-fall-through FIFO that sits directly upstream of spi_master.
- Its read side (get / out / empty) plugs into the master's source port exactly where a ROM or other byte source would.
- Its write side (put / in / full) accepts bytes from any producer, including the master's own receive port for loopback.
- It decouples producer burstiness from the strobe-paced SPI shifter.

---
 rtl/byte_fifo.sv | 65 ++++++
 tb/tb_byte_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO feeding the SPI master's byte source port.
// Occupancy is tracked by a dedicated counter so full and empty never hinge on pointer equality.
module byte_fifo #(
    parameter int W     = 8,
    parameter int ORDER = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             put,
    input  logic [W-1:0]     in,
    output logic             full,
    input  logic             get,
    output logic [W-1:0]     out,
    output logic             empty,
    output logic [ORDER:0]   level
);

    localparam int DEPTH = 1 << ORDER;
    localparam logic [ORDER:0] FULL_LEVEL = (ORDER+1)'(DEPTH);

    logic [W-1:0]       mem [DEPTH];
    logic [ORDER-1:0]   wp;
    logic [ORDER-1:0]   rp;
    logic               wr;
    logic               rd;
    logic [ORDER:0]     level_next;

    assign wr = put & ~full;
    assign rd = get & ~empty;

    always_comb begin
        level_next = level;
        if (wr && !rd) begin
            level_next = level + 1'b1;
        end else if (rd && !wr) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == FULL_LEVEL);
        end
    end

    // Storage is deliberately left unreset; flags keep stale contents invisible.
    always_ff @(posedge clock) begin
        if (wr && !reset) begin
            mem[wp] <= in;
        end
    end

    assign out = mem[rp];

endmodule

// File: tb/tb_byte_fifo.sv
// Self-checking bench for byte_fifo: queue-based reference model plus directed literal checks.
// Inputs change on the falling edge; all outputs are compared on the falling edge.
module tb_byte_fifo;

    localparam int W     = 8;
    localparam int ORDER = 4;
    localparam int DEPTH = 1 << ORDER;

    logic           clock;
    logic           reset;
    logic           put;
    logic [W-1:0]   in;
    logic           full;
    logic           get;
    logic [W-1:0]   out;
    logic           empty;
    logic [ORDER:0] level;

    int errors = 0;
    int checks = 0;
    bit checking = 0;
    logic [W-1:0] q[$];

    byte_fifo #(.W(W), .ORDER(ORDER)) dut (
        .clock (clock),
        .reset (reset),
        .put   (put),
        .in    (in),
        .full  (full),
        .get   (get),
        .out   (out),
        .empty (empty),
        .level (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a plain queue, updated from the inputs seen at each rising edge.
    always @(posedge clock) begin
        automatic bit do_wr = put && (q.size() < DEPTH);
        automatic bit do_rd = get && (q.size() > 0);
        if (reset) begin
            q.delete();
        end else begin
            if (do_rd) void'(q.pop_front());
            if (do_wr) q.push_back(in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            chk("model_level", 32'(level), 32'(q.size()));
            chk("model_empty", 32'(empty), 32'(q.size() == 0));
            chk("model_full",  32'(full),  32'(q.size() == DEPTH));
            if (q.size() > 0) chk("model_out", 32'(out), 32'(q[0]));
        end
    end

    // Present inputs for one rising edge; returns on the following falling edge.
    task automatic cyc(input logic p, input logic [W-1:0] d, input logic g);
        put = p;
        in  = d;
        get = g;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        put   = 1'b0;
        get   = 1'b0;
        in    = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        checking = 1;

        // idle after reset, stray gets must not move anything
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, i[0]);
            chk("idle_empty", 32'(empty), 1);
            chk("idle_full",  32'(full),  0);
            chk("idle_level", 32'(level), 0);
        end

        // single byte
        cyc(1'b1, 8'h48, 1'b0);
        chk("one_empty", 32'(empty), 0);
        chk("one_out",   32'(out),   32'h48);
        chk("one_level", 32'(level), 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("one_pop_empty", 32'(empty), 1);
        chk("one_pop_level", 32'(level), 0);

        // fill to full, overflow drop, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, W'(i), 1'b0);
        chk("fill_full",  32'(full),  1);
        chk("fill_level", 32'(level), 16);
        cyc(1'b1, 8'hAA, 1'b0);
        chk("drop_level", 32'(level), 16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_out", 32'(out), 32'(i));
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_level", 32'(level), 0);

        // half full, then sustained simultaneous put/get across several wraps
        for (int i = 0; i < 8; i++) cyc(1'b1, W'(8'h20 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk("stream_out", 32'(out), 32'(8'(8'h20 + i)));
            cyc(1'b1, W'(8'h28 + i), 1'b1);
            chk("stream_level", 32'(level), 8);
        end
        for (int i = 40; i < 48; i++) begin
            chk("stream_tail", 32'(out), 32'(8'(8'h20 + i)));
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("stream_empty", 32'(empty), 1);

        // full with put+get: read only
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, W'(8'h80 + i), 1'b0);
        cyc(1'b1, 8'h55, 1'b1);
        chk("fullpg_level", 32'(level), 15);
        chk("fullpg_full",  32'(full),  0);
        chk("fullpg_out",   32'(out),   32'h81);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("fullpg_drained", 32'(empty), 1);

        // empty with put+get: write only, no bypass
        cyc(1'b1, 8'h77, 1'b1);
        chk("emptypg_level", 32'(level), 1);
        chk("emptypg_out",   32'(out),   32'h77);
        chk("emptypg_empty", 32'(empty), 0);
        cyc(1'b0, 8'h00, 1'b1);

        // mid-stream reset discards "hello", then reload and read back
        begin
            logic [W-1:0] hello [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
            for (int i = 0; i < 5; i++) cyc(1'b1, hello[i], 1'b0);
            cyc(1'b0, 8'h00, 1'b1);
            reset = 1'b1;
            cyc(1'b1, 8'hEE, 1'b1);
            reset = 1'b0;
            chk("rst_empty", 32'(empty), 1);
            chk("rst_level", 32'(level), 0);
            chk("rst_full",  32'(full),  0);
            for (int i = 0; i < 5; i++) cyc(1'b1, hello[i], 1'b0);
            for (int i = 0; i < 5; i++) begin
                chk("hello_out", 32'(out), 32'(hello[i]));
                cyc(1'b0, 8'h00, 1'b1);
            end
            chk("hello_empty", 32'(empty), 1);
        end

        // randomized traffic with varying put/get bias and occasional resets
        for (int i = 0; i < 3000; i++) begin
            automatic int bias = (i / 500) % 3;
            automatic logic p = ($urandom_range(99) < (bias == 0 ? 70 : bias == 1 ? 30 : 50));
            automatic logic g = ($urandom_range(99) < (bias == 0 ? 30 : bias == 1 ? 70 : 50));
            reset = ($urandom_range(299) == 0);
            cyc(p, W'($urandom), g);
        end
        reset = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);

        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
